csram_loader: RTL and testbench
===============================

// Module: csram_loader
// PURPOSE
//  Programming front-end for a core's CSRAM.
//  - Accepts neuron configuration as a valid/ready stream of IN_WIDTH-bit chunks.
//  - Assembles each WIDTH-bit neuron word from those chunks.
//  - Writes the words into consecutive CSRAM addresses, starting at base_addr.
//  - Sits between the network/host config path and the CSRAM write port.
//  - Owns wen/address/data_in of that port only while a load is in progress.
// PARAMETERS
//  NUM_NEURONS  256  CSRAM depth; ADDR_W = $clog2(NUM_NEURONS)
//  WIDTH        367  CSRAM word width (neuron parameter record)
//  IN_WIDTH     32   input chunk width; CHUNKS = ceil(WIDTH/IN_WIDTH) (12 at defaults)
// PORTS
//  clk            in   1         system clock; all state on posedge
//  rst_n          in   1         asynchronous active-low reset
//  start          in   1         1-cycle request to begin a load (sampled in IDLE only)
//  abort          in   1         synchronous cancel of the load in progress
//  base_addr      in   ADDR_W    first CSRAM address written
//  num_words      in   ADDR_W+1  words to write, legal range 1..NUM_NEURONS
//  in_data        in   IN_WIDTH  config chunk; the first chunk of a word is its LSBs
//  in_valid       in   1         in_data valid
//  in_ready       out  1         loader accepts in_data this cycle
//  csram_wen      out  1         CSRAM write enable
//  csram_address  out  ADDR_W    CSRAM address
//  csram_data_in  out  WIDTH     CSRAM write data
//  busy           out  1         load in progress (LOAD or WRITE state)
//  done           out  1         1-cycle pulse: load completed normally
//  error          out  1         sticky: illegal start; cleared by the next legal start
// BEHAVIOUR
//  - Reset: every output is 0. The FSM goes to IDLE and the chunk/word counters clear.
//  - Reset is asynchronous. Asserting it mid-load drops csram_wen immediately and discards the partial word.
//  - All outputs are registered on posedge. CSRAM samples on negedge, so wen/address/data are stable at mid-cycle.
//  - FSM states: IDLE, LOAD, WRITE, DONE.
//  - IDLE -> LOAD when start=1 and the request is legal (num_words in 1..NUM_NEURONS, base_addr < NUM_NEURONS):
//      - cur_addr <= base_addr; remaining <= num_words; chunk_cnt <= 0; error <= 0.
//  - IDLE, illegal start: error <= 1; stay in IDLE; no write is ever issued.
//  - start outside IDLE is ignored.
//  - LOAD:
//      - in_ready=1. A chunk is accepted when in_valid && in_ready.
//      - Chunk k is placed at word bits [k*IN_WIDTH +: IN_WIDTH]. Bits at or above WIDTH in the last chunk are dropped.
//      - On acceptance of chunk CHUNKS-1, go to WRITE. in_ready falls in the same edge.
//  - WRITE:
//      - Exactly one cycle: csram_wen=1, csram_address=cur_addr, csram_data_in=assembled word.
//      - Then cur_addr advances by 1, wrapping from NUM_NEURONS-1 to 0; remaining decrements.
//      - If remaining reaches 0, go to DONE; otherwise go to LOAD with chunk_cnt=0.
//  - DONE: done=1 for one cycle, busy=0, then IDLE.
//  - Throughput: with in_valid held high, one word per CHUNKS+1 cycles.
//      - First in_ready is the cycle after start. First wen is CHUNKS cycles after the first in_ready.
//  - busy=1 in LOAD and WRITE only.
//  - csram_wen is never high outside WRITE. csram_address/data_in hold their last value when wen=0.
//  - abort=1 in LOAD or WRITE:
//      - Next state is IDLE with no done pulse and the partial word discarded.
//      - abort has priority over a coincident write, so no wen in that cycle.
//  - abort in IDLE or DONE: no effect.
//  - Backpressure: in_valid may drop at any time. No chunk is dropped or duplicated, and chunk order is preserved.
// TESTING
//  1. Assert rst_n=0 -> all outputs 0; release -> IDLE, in_ready=0.
//  2. start, base=0, num=2, in_valid=1, chunk n = 32'hA000_0000+n:
//     -> wen at addr 0 then addr 1, 13 cycles apart.
//     -> each word is the concatenation of its 12 chunks truncated to 367 bits.
//     -> done pulses the cycle after the second write.
//  3. Repeat scenario 2 with in_valid random at 50% -> identical written data; exactly 2 wen cycles; busy high throughout.
//  4. start, base=255, num=2 -> writes to addr 255 then addr 0; done=1.
//  5. start with num=0, then with num=257 -> error=1, no wen, busy=0.
//     Then a legal start -> error clears, load proceeds.
//  6. abort after 5 chunks, and separately rst_n=0 after 5 chunks -> no wen, busy=0, no done.
//     The next load's first word is assembled from chunk 0.

Source files
------------

// File: rtl/csram_loader.sv
// csram_loader: programming front-end for a core's CSRAM.
// Collects IN_WIDTH-bit chunks from a valid/ready stream, assembles WIDTH-bit
// neuron words (first chunk = LSBs), and writes them to consecutive CSRAM
// addresses starting at base_addr, wrapping at NUM_NEURONS.
module csram_loader #(
  parameter int NUM_NEURONS = 256,
  parameter int WIDTH       = 367,
  parameter int IN_WIDTH    = 32,
  localparam int ADDR_W     = $clog2(NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                csram_wen,
  output logic [ADDR_W-1:0]   csram_address,
  output logic [WIDTH-1:0]    csram_data_in,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int CHUNKS = (WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [WIDTH-1:0]  CHUNK_MASK = WIDTH'({IN_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  chunk_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic [WIDTH-1:0]  word_buf;
  logic [WIDTH-1:0]  word_next;
  logic [WIDTH-1:0]  in_ext;
  logic              start_legal;
  int unsigned       shamt;

  // Request legality: 1..NUM_NEURONS words, base inside the array
  always_comb begin
    start_legal = (num_words != '0) &&
                  (int'(num_words) <= NUM_NEURONS) &&
                  (int'(base_addr) < NUM_NEURONS);
  end

  // Current word with the incoming chunk merged into its slot; bits shifted
  // past WIDTH fall off, which truncates the final chunk
  always_comb begin
    shamt     = 32'(IN_WIDTH) * 32'(chunk_cnt);
    in_ext    = WIDTH'(in_data);
    word_next = (word_buf & ~(CHUNK_MASK << shamt)) | (in_ext << shamt);
  end

  // Load FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      chunk_cnt     <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      word_buf      <= '0;
      in_ready      <= 1'b0;
      csram_wen     <= 1'b0;
      csram_address <= '0;
      csram_data_in <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      csram_wen <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_legal) begin
              state     <= S_LOAD;
              cur_addr  <= base_addr;
              remaining <= num_words;
              chunk_cnt <= '0;
              error     <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // abort wins over the final chunk, so no write can follow it
          if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (in_valid) begin
            word_buf <= word_next;
            if (chunk_cnt == LAST_CHUNK) begin
              state         <= S_WRITE;
              in_ready      <= 1'b0;
              csram_wen     <= 1'b1;
              csram_address <= cur_addr;
              csram_data_in <= word_next;
            end else begin
              chunk_cnt <= chunk_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            chunk_cnt <= '0;
            if (remaining == (ADDR_W + 1)'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csram_loader.sv
// tb_csram_loader: randomized self-checking bench for csram_loader.
// Expected words are built from the chunk stream by plain bit arithmetic.
module tb_csram_loader;

  localparam int NN       = 256;
  localparam int WIDTH    = 367;
  localparam int IN_WIDTH = 32;
  localparam int ADDR_W   = $clog2(NN);
  localparam int CHUNKS   = (WIDTH + IN_WIDTH - 1) / IN_WIDTH;

  typedef logic [WIDTH-1:0] val_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     num_words = '0;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                csram_wen;
  logic [ADDR_W-1:0]   csram_address;
  logic [WIDTH-1:0]    csram_data_in;
  logic                busy;
  logic                done;
  logic                error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [IN_WIDTH-1:0] src_q[$];

  csram_loader #(
    .NUM_NEURONS(NN),
    .WIDTH(WIDTH),
    .IN_WIDTH(IN_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .base_addr(base_addr),
    .num_words(num_words),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .csram_wen(csram_wen),
    .csram_address(csram_address),
    .csram_data_in(csram_data_in),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word w = chunks w*CHUNKS .. w*CHUNKS+CHUNKS-1 laid LSB-first, cut at WIDTH
  function automatic val_t word_of(input int w);
    val_t r = '0;
    for (int k = 0; k < CHUNKS; k++)
      for (int b = 0; b < IN_WIDTH; b++)
        if (k * IN_WIDTH + b < WIDTH)
          r[k * IN_WIDTH + b] = src_q[w * CHUNKS + k][b];
    return r;
  endfunction

  // One full load; chunks either 32'hA000_0000+n or random
  task automatic do_load(input int base, input int num, input bit rnd,
                         input bit seq_data, input bit timing_chk);
    int fed = 0, wen_cnt = 0, first_rdy = -1, first_wen = -1;
    int last_wen = -1, done_cyc = -1;
    int budget = num * (CHUNKS + 1) * 8 + 40;
    bit busy_low = 1'b0;
    src_q.delete();
    for (int n = 0; n < num * CHUNKS; n++)
      src_q.push_back(seq_data ? 32'hA000_0000 + 32'(n) : $urandom);
    @(negedge clk);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W + 1)'(num);
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_ready && first_rdy < 0) first_rdy = cyc;
      if (csram_wen) begin
        if (wen_cnt < num) begin
          check("wen_addr", val_t'((base + wen_cnt) % NN), val_t'(csram_address));
          check("wen_data", csram_data_in, word_of(wen_cnt));
          if (timing_chk && wen_cnt > 0)
            check("wen_gap", val_t'(cyc - last_wen), val_t'(CHUNKS + 1));
        end
        if (first_wen < 0) first_wen = cyc;
        last_wen = cyc;
        wen_cnt++;
      end
      if (done) done_cyc = cyc;
      else if (!busy) busy_low = 1'b1;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fed >= num * CHUNKS) in_valid = 1'b0;
      in_data = in_valid ? src_q[fed] : $urandom;
      if (in_valid && in_ready) fed++;
    end
    in_valid = 1'b0;
    check("done_seen", val_t'(done_cyc >= 0), val_t'(1));
    check("wen_count", val_t'(wen_cnt), val_t'(num));
    check("busy_held", val_t'(busy_low), val_t'(0));
    check("done_after_wen", val_t'(done_cyc - last_wen), val_t'(1));
    if (timing_chk) begin
      check("first_ready", val_t'(first_rdy), val_t'(1));
      check("first_wen", val_t'(first_wen - first_rdy), val_t'(CHUNKS));
    end
    @(negedge clk);
    check("done_pulse", val_t'(done), val_t'(0));
    check("idle_busy", val_t'(busy), val_t'(0));
  endtask

  // Illegal request: error rises, nothing starts, nothing is written
  task automatic bad_start(input int base, input int num);
    bit saw = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W + 1)'(num);
    @(negedge clk);
    start = 1'b0;
    check("err_set", val_t'(error), val_t'(1));
    check("err_busy", val_t'(busy), val_t'(0));
    check("err_ready", val_t'(in_ready), val_t'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (csram_wen || busy || done) saw = 1'b1;
    end
    check("err_quiet", val_t'(saw), val_t'(0));
    check("err_sticky", val_t'(error), val_t'(1));
  endtask

  // Cancel after 5 chunks, by abort or by reset
  task automatic cancel_load(input bit use_reset);
    bit saw = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = ADDR_W'($urandom_range(0, NN - 1));
    num_words = (ADDR_W + 1)'(2);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
    end
    in_data = $urandom;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_wen", val_t'(csram_wen), val_t'(0));
      check("rst_busy", val_t'(busy), val_t'(0));
      check("rst_ready", val_t'(in_ready), val_t'(0));
    end else begin
      abort = 1'b1;
    end
    @(negedge clk);
    rst_n    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("cancel_busy", val_t'(busy), val_t'(0));
    check("cancel_ready", val_t'(in_ready), val_t'(0));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (csram_wen || busy || done) saw = 1'b1;
    end
    check("cancel_quiet", val_t'(saw), val_t'(0));
  endtask

  initial begin
    #1;
    check("reset_wen", val_t'(csram_wen), val_t'(0));
    check("reset_addr", val_t'(csram_address), val_t'(0));
    check("reset_data", csram_data_in, val_t'(0));
    check("reset_busy", val_t'(busy), val_t'(0));
    check("reset_done", val_t'(done), val_t'(0));
    check("reset_error", val_t'(error), val_t'(0));
    check("reset_ready", val_t'(in_ready), val_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", val_t'(in_ready), val_t'(0));

    do_load(0, 2, 1'b0, 1'b1, 1'b1);
    do_load(0, 2, 1'b1, 1'b1, 1'b0);
    do_load(255, 2, 1'b0, 1'b0, 1'b1);

    bad_start(0, 0);
    bad_start(0, 257);
    do_load(10, 1, 1'b0, 1'b0, 1'b1);
    check("err_cleared", val_t'(error), val_t'(0));

    cancel_load(1'b0);
    do_load(20, 1, 1'b0, 1'b0, 1'b1);
    cancel_load(1'b1);
    do_load(30, 1, 1'b1, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++)
      do_load($urandom_range(0, NN - 1), $urandom_range(1, 4),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
